// File: rtl/uart_reg_decoder.sv
// uart_reg_decoder: parses 'W' addr data / 'R' addr frames from the UART receiver into a debug register bank.
// Latency: ack 1 cycle after rxValid is sampled; register write visible 1 cycle after data byte; read txSend 2 cycles after address.
// Backpressure: bytes are only taken (acked) in IDLE/ADDR/DATA; SEND holds while txBusy=1, WAIT holds until txBusy falls or txErr.
//
// Optional feature macro: UART_REG_DECODER_WRITE_ECHO_EN
//   defined   -> a successful write goes through SEND/WAIT and echoes the written value
//   undefined -> writes return to IDLE with no transmission
//
// Ports:
//   clk, rstb                  clock, asynchronous active-high reset
//   rxValid/rxData/rxErr/rxAck receiver side; byte held until the one-cycle rxAck
//   txBusy/txErr/txSend/txData transmitter side; txData held from txSend until txBusy falls
//   regs                       flattened register bank, register i at [(i+1)*W-1 : i*W]
//   busy                       high whenever the parser is not in IDLE
//   errPulse/errCount          one-cycle error strobe and saturating error counter

module uart_reg_decoder #(
    parameter int C_UART_DATA_WIDTH = 8,
    parameter int C_REG_COUNT       = 16,
    parameter int C_REG_WIDTH       = 8,
    parameter int C_TIMEOUT         = 1_000_000
) (
    input  logic                               clk,
    input  logic                               rstb,
    input  logic                               rxValid,
    input  logic [C_UART_DATA_WIDTH-1:0]       rxData,
    input  logic                               rxErr,
    output logic                               rxAck,
    input  logic                               txBusy,
    input  logic                               txErr,
    output logic                               txSend,
    output logic [C_UART_DATA_WIDTH-1:0]       txData,
    output logic [C_REG_COUNT*C_REG_WIDTH-1:0] regs,
    output logic                               busy,
    output logic                               errPulse,
    output logic [7:0]                         errCount
);

    localparam int ADDR_W = (C_REG_COUNT > 1) ? $clog2(C_REG_COUNT) : 1;
    localparam int TMO_W  = $clog2(C_TIMEOUT + 1);

    localparam logic [TMO_W-1:0]             TMO_LAST  = TMO_W'(C_TIMEOUT - 1);
    localparam logic [C_UART_DATA_WIDTH:0]   REG_LIMIT = (C_UART_DATA_WIDTH + 1)'(C_REG_COUNT);
    localparam logic [C_UART_DATA_WIDTH-1:0] CMD_WRITE = C_UART_DATA_WIDTH'(8'h57);
    localparam logic [C_UART_DATA_WIDTH-1:0] CMD_READ  = C_UART_DATA_WIDTH'(8'h52);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_SEND,
        S_WAIT
    } state_t;

    state_t                   state;
    logic                     isWrite;
    logic [ADDR_W-1:0]        addrReg;
    logic [C_REG_WIDTH-1:0]   regFile [C_REG_COUNT];
    logic [TMO_W-1:0]         tmoCnt;
    logic                     txBusyPrev;

    logic                          rxStates;
    logic                          rxTake;
    logic                          addrOk;
    logic                          tmoStates;
    logic                          tmoHit;
    logic                          txFall;
    logic                          errDetect;
    logic [C_UART_DATA_WIDTH-1:0]  regVal;

    always_comb begin
        rxStates  = (state == S_IDLE) || (state == S_ADDR) || (state == S_DATA);
        // The byte is still presented during the ack cycle; skipping that
        // cycle stops the same byte from being consumed twice.
        rxTake    = rxValid && !rxAck && rxStates;
        addrOk    = ({1'b0, rxData} < REG_LIMIT);
        tmoStates = (state == S_ADDR) || (state == S_DATA);
        tmoHit    = tmoStates && (tmoCnt == TMO_LAST);
        txFall    = txBusyPrev && !txBusy;

        regVal = '0;
        regVal[C_REG_WIDTH-1:0] = regFile[addrReg];

        // A byte arriving on the timeout cycle takes priority over the timeout.
        errDetect = (rxTake && rxErr)
                 || (rxTake && !rxErr && (state == S_ADDR) && !addrOk)
                 || (!rxTake && tmoHit)
                 || ((state == S_WAIT) && txErr);
    end

    always_ff @(posedge clk or posedge rstb) begin
        if (rstb) begin
            state      <= S_IDLE;
            isWrite    <= 1'b0;
            addrReg    <= '0;
            tmoCnt     <= '0;
            txBusyPrev <= 1'b0;
            rxAck      <= 1'b0;
            txSend     <= 1'b0;
            txData     <= '0;
            errPulse   <= 1'b0;
            errCount   <= 8'd0;
            for (int i = 0; i < C_REG_COUNT; i++) begin
                regFile[i] <= '0;
            end
        end else begin
            rxAck      <= rxTake;
            txSend     <= 1'b0;
            txBusyPrev <= txBusy;
            errPulse   <= errDetect;
            if (errDetect && (errCount != 8'hFF)) begin
                errCount <= errCount + 8'd1;
            end

            // Idle-time counter between bytes of one frame.
            if (rxTake || !tmoStates || tmoHit) begin
                tmoCnt <= '0;
            end else begin
                tmoCnt <= tmoCnt + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    // Unknown bytes are acked and dropped without an error.
                    if (rxTake && !rxErr) begin
                        if (rxData == CMD_WRITE) begin
                            isWrite <= 1'b1;
                            state   <= S_ADDR;
                        end else if (rxData == CMD_READ) begin
                            isWrite <= 1'b0;
                            state   <= S_ADDR;
                        end
                    end
                end

                S_ADDR: begin
                    if (rxTake) begin
                        if (rxErr || !addrOk) begin
                            state <= S_IDLE;
                        end else begin
                            addrReg <= rxData[ADDR_W-1:0];
                            state   <= isWrite ? S_DATA : S_SEND;
                        end
                    end else if (tmoHit) begin
                        state <= S_IDLE;
                    end
                end

                S_DATA: begin
                    if (rxTake) begin
                        if (rxErr) begin
                            state <= S_IDLE;
                        end else begin
                            regFile[addrReg] <= rxData[C_REG_WIDTH-1:0];
`ifdef UART_REG_DECODER_WRITE_ECHO_EN
                            // SEND reads the register after this write lands,
                            // so the echo carries the new value.
                            state <= S_SEND;
`else
                            state <= S_IDLE;
`endif
                        end
                    end else if (tmoHit) begin
                        state <= S_IDLE;
                    end
                end

                S_SEND: begin
                    if (!txBusy) begin
                        txSend <= 1'b1;
                        txData <= regVal;
                        state  <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (txErr || txFall) begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (state != S_IDLE);

    for (genvar i = 0; i < C_REG_COUNT; i++) begin : g_regs
        assign regs[i*C_REG_WIDTH +: C_REG_WIDTH] = regFile[i];
    end

endmodule

// File: doc/uart_reg_decoder.md
# uart_reg_decoder

Command decoder on the receive side of the UART link. It consumes bytes from the UART receiver through the valid/ack handshake and parses write and read frames. Writes update a bank of debug registers; reads send the register value back through the UART transmitter. It sits between the UART receiver and transmitter (or the mirror module's pass-through ports) and feeds debug registers to LEDs and fabric.

## Interface
- C_UART_DATA_WIDTH, 8, byte width on both UART sides; fixed at 8 for this protocol.
- C_REG_COUNT, 16, number of registers; power of 2, from 2 to 256.
- C_REG_WIDTH, 8, register width in bits; from 1 to 8; values are taken from data LSBs.
- C_TIMEOUT, 1_000_000, maximum idle cycles between bytes of one frame.

Ports:
- clk  in  1  system clock.
- rstb  in  1  reset, asynchronous, active-high (the name is kept uniform with other blocks; polarity is high).
- rxValid  in  1  receiver holds a byte; held until acked.
- rxData  in  8  received byte.
- rxErr  in  1  framing/parity error flag for the byte held.
- rxAck  out  1  one-cycle acknowledge of the held byte.
- txBusy  in  1  transmitter busy.
- txErr  in  1  transmitter error.
- txSend  out  1  one-cycle send request.
- txData  out  8  byte to send; stable from txSend until txBusy falls.
- regs  out  C_REG_COUNT*C_REG_WIDTH  flattened registers; register i is at [(i+1)*W-1 : i*W].
- busy  out  1  high in every state except IDLE.
- errPulse  out  1  one-cycle pulse for each protocol error.
- errCount  out  8  count of errors, saturating at 255.

## Operation
- Frame formats:
  - Write: 0x57 ('W'), address byte, data byte.
  - Read: 0x52 ('R'), address byte.
- Address check: the address byte must be below C_REG_COUNT. Otherwise the frame aborts with an error and no write occurs.
- States:
  - IDLE: on a 'W' or 'R' byte, go to ADDR. Any other byte is acked and silently ignored; it is not counted as an error.
  - ADDR: a valid address goes to DATA for a write, or to SEND for a read.
  - DATA: the data byte is written and the block returns to IDLE.
  - SEND: txSend pulses with txData = the register value, zero-extended. Then go to WAIT.
  - WAIT: on txBusy falling, go to IDLE. On txErr, raise an error and go to IDLE.
- Every byte seen in IDLE, ADDR or DATA is acked, including bytes with rxErr.
- rxErr=1 in any state aborts the frame to IDLE, raises an error, and discards the byte.
- Timeout counter:
  - Cleared on each accepted byte.
  - Counts only in ADDR and DATA.
  - At C_TIMEOUT-1 it raises an error and forces IDLE.
- Register write and timeout in the same cycle: the byte wins and the timeout is discarded.
- Reset values: all regs 0, rxAck 0, txSend 0, txData 0, busy 0, errPulse 0, errCount 0, state IDLE, timeout counter 0.
- Reset mid-frame: the partial frame is lost. A pending rxValid is not acked until after reset is released.

## Timing
- Acknowledge: rxValid sampled high in cycle N gives rxAck=1 in cycle N+1. rxValid is not sampled during the ack cycle.
- State change: takes effect in cycle N+1.
- Write latency: data byte sampled in cycle N, register updated from cycle N+1.
- Read latency: address sampled in cycle N, txSend=1 in cycle N+2. It is delayed while txBusy=1.
- Send rule: txSend is asserted only while txBusy=0, and for exactly one cycle.
- Error reporting: errPulse is high in the cycle after the error is detected. errCount increments in the same cycle.

## Configuration
- Macro: UART_REG_DECODER_WRITE_ECHO_EN.
- Defined: after a successful write the block goes to SEND and echoes the written value, zero-extended. Write frames then complete in WAIT, like reads.
- Undefined: writes produce no transmission. The echo states and logic are not compiled.

## Test plan
- Write/read round trip: bytes 0x57,0x03,0xA5, then 0x52,0x03 -> regs[31:24]=0xA5 one cycle after the third byte; txSend pulse with txData=0xA5; all other registers stay 0.
- Bad address: 0x57,0x10,0x11 with C_REG_COUNT=16 -> errPulse once, errCount=1, no register change. The byte 0x11 is then handled in IDLE and ignored.
- Receive error: 0x57, then 0x02 with rxErr=1 -> abort to IDLE, errCount=1. The following 0x57,0x02,0x0F writes regs[2]=0x0F.
- Timeout: 0x57, then no byte for C_TIMEOUT cycles -> errPulse at the timeout, busy=0, registers unchanged.
- Transmitter busy: a read issued while txBusy=1 -> no txSend until txBusy=0, then one txSend. txErr during WAIT -> errCount+1.
- Reset mid-frame: assert rstb after 0x57,0x01 -> all outputs 0 immediately, state IDLE. With the echo macro defined, a write 0x57,0x00,0x3C echoes 0x3C.
